// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the requesters/decode and the register-file write arbiter.
// The slave modport is the arbiter's view; master is the requester/decode side.
interface regfile_wb_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_ready;
  logic [3*NUM_SRC-1:0]  src_dr;
  logic [16*NUM_SRC-1:0] src_data;
  logic                  rsv_valid;
  logic [2:0]            rsv_dr;
  logic                  flush;
  logic                  RegWE;
  logic [2:0]            DR;
  logic [15:0]           write_value;
  logic [7:0]            pend_mask;
  logic [2:0]            sr1;
  logic [2:0]            sr2;
  logic                  byp1_hit;
  logic                  byp2_hit;
  logic [15:0]           byp1_data;
  logic [15:0]           byp2_data;

  modport master (
    output src_valid, src_dr, src_data, rsv_valid, rsv_dr, flush, sr1, sr2,
    input  src_ready, RegWE, DR, write_value, pend_mask,
           byp1_hit, byp2_hit, byp1_data, byp2_data
  );

  modport slave (
    input  src_valid, src_dr, src_data, rsv_valid, rsv_dr, flush, sr1, sr2,
    output src_ready, RegWE, DR, write_value, pend_mask,
           byp1_hit, byp2_hit, byp1_data, byp2_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a pending-write scoreboard.
// Optional macro RF_WB_BYPASS_EN enables forwarding from the registered write stage.
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int RR_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic [RR_W-1:0]    rr_ptr;
  logic [NUM_SRC-1:0] grant;
  logic               found;
  logic [RR_W-1:0]    win_idx;
  logic [2:0]         win_dr;
  logic [15:0]        win_data;
  logic               vld_p1;
  logic [2:0]         dr_p1;
  logic [15:0]        wv_p1;
  logic [7:0]         pend;
  logic [7:0]         pend_next;

  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] w);
    if (w == RR_W'(NUM_SRC - 1)) rr_next = '0;
    else                         rr_next = w + 1'b1;
  endfunction

  // Two passes: first sources at or above the pointer, then wrap to the lowest valid one.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    win_idx  = '0;
    win_dr   = '0;
    win_data = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && bus.src_valid[j] && (RR_W'(j) >= rr_ptr)) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win_idx  = RR_W'(j);
        win_dr   = bus.src_dr[3*j +: 3];
        win_data = bus.src_data[16*j +: 16];
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!found && bus.src_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win_idx  = RR_W'(j);
        win_dr   = bus.src_dr[3*j +: 3];
        win_data = bus.src_data[16*j +: 16];
      end
    end
    if (bus.flush || rst) begin
      grant = '0;
      found = 1'b0;
    end
  end

  assign bus.src_ready = grant;

  // A reservation and a retirement of the same register collide: the reservation wins.
  always_comb begin
    pend_next = pend;
    if (vld_p1)        pend_next[dr_p1]      = 1'b0;
    if (bus.rsv_valid) pend_next[bus.rsv_dr] = 1'b1;
    if (bus.flush)     pend_next             = '0;
  end

  // Stage p0 -> p1: register the granted write onto the register-file port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      vld_p1 <= 1'b0;
      dr_p1  <= '0;
      wv_p1  <= '0;
      pend   <= '0;
    end else begin
      vld_p1 <= found;
      pend   <= pend_next;
      if (found) begin
        dr_p1  <= win_dr;
        wv_p1  <= win_data;
        rr_ptr <= rr_next(win_idx);
      end
    end
  end

  assign bus.RegWE       = vld_p1;
  assign bus.DR          = dr_p1;
  assign bus.write_value = wv_p1;
  assign bus.pend_mask   = pend;

`ifdef RF_WB_BYPASS_EN
  assign bus.byp1_hit  = vld_p1 && (dr_p1 == bus.sr1);
  assign bus.byp2_hit  = vld_p1 && (dr_p1 == bus.sr2);
  assign bus.byp1_data = wv_p1;
  assign bus.byp2_data = wv_p1;
`else
  logic unused_sr;
  assign unused_sr     = ^{bus.sr1, bus.sr2};
  assign bus.byp1_hit  = 1'b0;
  assign bus.byp2_hit  = 1'b0;
  assign bus.byp1_data = '0;
  assign bus.byp2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: grant table with write scoreboard,
// plus hand sequences for scoreboard, flush, bypass and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.NUM_SRC(3)) rf ();

  regfile_wb_arbiter #(.NUM_SRC(3), .RR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] valid;
    logic       flush;
    logic [2:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
  } wr_t;

  vec_t        vecs [15];
  wr_t         sb_q [$];
  wr_t         got;
  logic [2:0]  dr_tab [3];
  logic [15:0] data_tab [3];
  logic        exp_h1;
  logic [15:0] exp_d1;
  int          nvec;
  int          nerr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_sources();
    rf.src_dr   = {dr_tab[2], dr_tab[1], dr_tab[0]};
    rf.src_data = {data_tab[2], data_tab[1], data_tab[0]};
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    dr_tab[0] = 3'd1; data_tab[0] = 16'h1110;
    dr_tab[1] = 3'd3; data_tab[1] = 16'h2220;
    dr_tab[2] = 3'd6; data_tab[2] = 16'hBEEF;

    // Pointer is 1 when the table starts (after the single-source write).
    vecs[0]  = '{3'b100, 1'b0, 3'b100};
    vecs[1]  = '{3'b111, 1'b0, 3'b001};
    vecs[2]  = '{3'b111, 1'b0, 3'b010};
    vecs[3]  = '{3'b111, 1'b0, 3'b100};
    vecs[4]  = '{3'b111, 1'b0, 3'b001};
    vecs[5]  = '{3'b111, 1'b0, 3'b010};
    vecs[6]  = '{3'b111, 1'b0, 3'b100};
    vecs[7]  = '{3'b000, 1'b0, 3'b000};
    vecs[8]  = '{3'b110, 1'b0, 3'b010};
    vecs[9]  = '{3'b011, 1'b0, 3'b001};
    vecs[10] = '{3'b101, 1'b0, 3'b100};
    vecs[11] = '{3'b000, 1'b0, 3'b000};
    vecs[12] = '{3'b101, 1'b1, 3'b000};
    vecs[13] = '{3'b101, 1'b0, 3'b001};
    vecs[14] = '{3'b000, 1'b0, 3'b000};

    rst          = 1'b1;
    rf.src_valid = 3'b111;
    rf.rsv_valid = 1'b0;
    rf.rsv_dr    = 3'd0;
    rf.flush     = 1'b0;
    rf.sr1       = 3'd0;
    rf.sr2       = 3'd0;
    set_default_sources();
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwe", rf.RegWE, 0);
    check("rst_dr", rf.DR, 0);
    check("rst_wv", rf.write_value, 0);
    check("rst_pend", rf.pend_mask, 0);
    check("rst_ready", rf.src_ready, 0);
    check("rst_byp1", {rf.byp1_hit, rf.byp1_data}, 0);
    check("rst_byp2", {rf.byp2_hit, rf.byp2_data}, 0);
    rf.src_valid = 3'b000;
    rst          = 1'b0;
    tick();

    // Single source write with 1-cycle latency.
    rf.src_dr[2:0]    = 3'd5;
    rf.src_data[15:0] = 16'h1234;
    rf.src_valid      = 3'b001;
    #1;
    check("single_ready", rf.src_ready, 3'b001);
    @(posedge clk);
    #1;
    rf.src_valid = 3'b000;
    check("single_regwe", rf.RegWE, 1);
    check("single_dr", rf.DR, 5);
    check("single_wv", rf.write_value, 16'h1234);
    tick();
    check("single_regwe_off", rf.RegWE, 0);
    check("single_dr_hold", rf.DR, 5);
    check("single_wv_hold", rf.write_value, 16'h1234);
    set_default_sources();

    // Grant table; each grant pushes the expected write, each RegWE pops it.
    for (int i = 0; i < 15; i++) begin
      rf.src_valid = vecs[i].valid;
      rf.flush     = vecs[i].flush;
      #1;
      check($sformatf("rr_grant[%0d]", i), rf.src_ready, vecs[i].exp_ready);
      for (int b = 0; b < 3; b++)
        if (vecs[i].exp_ready[b]) sb_q.push_back('{dr_tab[b], data_tab[b]});
      tick();
      check($sformatf("rr_we[%0d]", i), rf.RegWE, (vecs[i].exp_ready != 3'b000));
      if (rf.RegWE && sb_q.size() > 0) begin
        got = sb_q.pop_front();
        check($sformatf("rr_dr[%0d]", i), rf.DR, got.dr);
        check($sformatf("rr_wv[%0d]", i), rf.write_value, got.data);
      end
    end
    rf.src_valid = 3'b000;
    rf.flush     = 1'b0;
    check("sb_drained", sb_q.size(), 0);

    // Reserve r3, then retire it through source 1 (pointer at 1).
    rf.rsv_valid = 1'b1;
    rf.rsv_dr    = 3'd3;
    tick();
    rf.rsv_valid = 1'b0;
    check("pend_set", rf.pend_mask, 8'h08);
    rf.src_valid = 3'b010;
    #1;
    check("pend_src1_ready", rf.src_ready, 3'b010);
    @(posedge clk);
    #1;
    rf.src_valid = 3'b000;
    check("pend_wr_we", rf.RegWE, 1);
    check("pend_wr_dr", rf.DR, 3);
    check("pend_during_we", rf.pend_mask, 8'h08);
    tick();
    check("pend_cleared", rf.pend_mask, 8'h00);

    // Reservation colliding with retirement of the same register (pointer at 2).
    rf.rsv_valid = 1'b1;
    rf.rsv_dr    = 3'd3;
    tick();
    rf.rsv_valid = 1'b0;
    rf.src_valid = 3'b010;
    #1;
    check("wrap_src1_ready", rf.src_ready, 3'b010);
    @(posedge clk);
    #1;
    rf.src_valid = 3'b000;
    rf.rsv_valid = 1'b1;
    rf.rsv_dr    = 3'd3;
    check("collide_we", rf.RegWE, 1);
    tick();
    rf.rsv_valid = 1'b0;
    check("collide_set_wins", rf.pend_mask, 8'h08);

    // Flush clears the scoreboard and ignores the same-cycle reservation.
    rf.flush     = 1'b1;
    rf.rsv_valid = 1'b1;
    rf.rsv_dr    = 3'd4;
    tick();
    rf.flush     = 1'b0;
    rf.rsv_valid = 1'b0;
    check("flush_pend", rf.pend_mask, 8'h00);
    for (int r = 0; r < 8; r++) begin
      if (r == 0 || r == 2 || r == 5 || r == 7) begin
        rf.rsv_valid = 1'b1;
        rf.rsv_dr    = 3'(r);
        tick();
      end
    end
    rf.rsv_valid = 1'b0;
    check("pend_a5", rf.pend_mask, 8'hA5);
    rf.src_valid = 3'b001;
    #1;
    check("flush_pre_ready", rf.src_ready, 3'b001);
    @(posedge clk);
    #1;
    rf.src_valid = 3'b100;
    rf.flush     = 1'b1;
    #1;
    check("flush_ready", rf.src_ready, 3'b000);
    check("flush_inflight_we", rf.RegWE, 1);
    check("flush_inflight_dr", rf.DR, 1);
    @(posedge clk);
    #1;
    rf.flush = 1'b0;
    check("flush_pend_zero", rf.pend_mask, 8'h00);
    check("flush_no_write", rf.RegWE, 0);
    rf.src_valid = 3'b101;
    #1;
    check("flush_ptr_held", rf.src_ready, 3'b100);
    @(posedge clk);
    #1;
    rf.src_valid = 3'b000;
    rf.sr1       = 3'd6;
    rf.sr2       = 3'd2;
    #1;
    check("byp_we", rf.RegWE, 1);
    check("byp_dr", rf.DR, 6);
    check("byp_wv", rf.write_value, 16'hBEEF);
`ifdef RF_WB_BYPASS_EN
    exp_h1 = 1'b1;
    exp_d1 = 16'hBEEF;
`else
    exp_h1 = 1'b0;
    exp_d1 = 16'h0000;
`endif
    check("byp1_hit", rf.byp1_hit, exp_h1);
    check("byp1_data", rf.byp1_data, exp_d1);
    check("byp2_hit", rf.byp2_hit, 0);
    tick();

    // Asynchronous reset in the middle of a registered write.
    rf.rsv_valid = 1'b1;
    rf.rsv_dr    = 3'd5;
    rf.src_valid = 3'b001;
    @(posedge clk);
    #1;
    rf.rsv_valid = 1'b0;
    check("mid_we", rf.RegWE, 1);
    check("mid_pend", rf.pend_mask, 8'h20);
    rst = 1'b1;
    #1;
    check("arst_we", rf.RegWE, 0);
    check("arst_dr", rf.DR, 0);
    check("arst_wv", rf.write_value, 0);
    check("arst_pend", rf.pend_mask, 0);
    check("arst_ready", rf.src_ready, 0);
    check("arst_byp1", rf.byp1_hit, 0);
    @(posedge clk);
    #1;
    rf.src_valid = 3'b000;
    rst          = 1'b0;
    tick();
    check("post_rst_no_write", rf.RegWE, 0);
    rf.src_valid = 3'b111;
    #1;
    check("post_rst_ptr0", rf.src_ready, 3'b001);
    rf.src_valid = 3'b000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 8x16-bit register file between NUM_SRC write-back requesters, such as ALU result, memory load and PC/link save.
- Selects at most one requester per cycle by round-robin and registers the winner onto the register-file write signals.
- Keeps a per-register pending scoreboard so decode can stall on registers with an outstanding write.
- Sits between the execute/memory stages and the register file.

Parameters:
NUM_SRC, 3, number of write-back requesters (2..8)
RR_W, 3, width of the round-robin pointer; must satisfy 2**RR_W >= NUM_SRC

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
src_valid  in  NUM_SRC  per-source write request
src_ready  out  NUM_SRC  per-source grant; combinational, one-hot or zero
src_dr  in  3*NUM_SRC  packed destination register; source i at bits [3i+2:3i]
src_data  in  16*NUM_SRC  packed write data; source i at bits [16i+15:16i]
rsv_valid  in  1  decode reserves a destination register
rsv_dr  in  3  register being reserved
flush  in  1  pipeline flush
RegWE  out  1  register-file write enable
DR  out  3  register-file write address
write_value  out  16  register-file write data
pend_mask  out  8  bit r=1 while a write to register r is outstanding
sr1, sr2  in  3 each  bypass lookup addresses (used only with the optional feature)
byp1_hit, byp2_hit  out  1 each  bypass hit flags
byp1_data, byp2_data  out  16 each  bypass data

Behaviour:
- Reset values: RegWE=0, DR=0, write_value=0, pend_mask=0, rr_ptr=0, src_ready=0, all byp outputs 0. Reset asserted mid-operation clears everything immediately; an in-flight write is dropped.
- Arbitration:
  - Scan sources starting at rr_ptr, wrapping modulo NUM_SRC; the first with src_valid=1 wins and gets src_ready=1.
  - No valid sources: src_ready=0 and rr_ptr unchanged.
  - A transfer occurs on src_valid && src_ready. A source must hold valid, dr and data stable until granted.
- Pointer update: after a transfer from source w, rr_ptr <= (w+1) mod NUM_SRC. The wrap from NUM_SRC-1 goes to 0.
- Output stage, 1-cycle latency:
  - On a transfer: RegWE<=1, DR<=winner dr, write_value<=winner data on the next edge.
  - Otherwise: RegWE<=0, and DR and write_value hold their previous values.
  - The register file captures the value on the following edge, so data is architecturally visible 2 edges after the grant.
- Scoreboard:
  - rsv_valid sets pend_mask[rsv_dr].
  - RegWE=1 clears pend_mask[DR].
  - A set and a clear of the same register in one cycle: the set wins, because the newer instruction owns the register.
  - Reserving an already-pending register leaves it pending; there is no count.
- Flush:
  - pend_mask<=0. src_ready is forced 0 that cycle and rr_ptr is held.
  - A write already registered in the output stage still completes (RegWE stays as registered).
  - rsv_valid in the flush cycle is ignored.
- Writes to R0 are ordinary writes; there is no hardwired zero register.
- With NUM_SRC=1, src_ready equals src_valid and rr_ptr stays 0.

Optional Feature:
RF_WB_BYPASS_EN:
- Defined:
  - byp1_hit = RegWE && (DR==sr1), with byp1_data = write_value.
  - byp2_hit and byp2_data behave the same using sr2.
  - These are purely combinational from the output register, so decode can forward a value the register file has not yet captured.
- Undefined: byp*_hit=0 and byp*_data=0 constantly; sr1 and sr2 are unused.

Test Plan:
- Reset: assert rst mid-write with RegWE=1 -> all outputs and pend_mask=0 immediately; after release, no write occurs.
- Single source: src_valid[0]=1, dr=5, data=16'h1234 -> src_ready[0]=1 the same cycle; next cycle RegWE=1, DR=5, write_value=16'h1234; the cycle after, RegWE=0.
- Round-robin fairness: all 3 sources valid continuously with rr_ptr=0 -> grants in order 0,1,2,0,1,2; exactly one src_ready high per cycle.
- Scoreboard: rsv_dr=3, then source 1 writes dr=3 -> pend_mask=8'h08 until the RegWE cycle, then 8'h00. With a simultaneous rsv_dr=3 in the RegWE cycle, pend_mask stays 8'h08.
- Flush: pend_mask=8'hA5 with source 2 valid and flush=1 -> pend_mask=0, src_ready=0 and rr_ptr unchanged that cycle; a registered write still appears on RegWE.
- Bypass (RF_WB_BYPASS_EN defined): RegWE=1, DR=6, write_value=16'hBEEF, sr1=6, sr2=2 -> byp1_hit=1, byp1_data=16'hBEEF, byp2_hit=0. Without the macro, both hits are 0.
